derived_clock_meter: RTL

- Measures a slow square wave produced by the team's programmable clock dividers, which toggle every N+1 fast-clock cycles.
- Reports period, high time and the recovered divider setting N, all counted in fast-clock cycles.
- Sits on the monitor/readback path so software can check a divider output against its programmed value.
- Also flags loss of signal (timeout) and a stable lock.

---
 rtl/derived_clock_meter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/derived_clock_meter.sv
// derived_clock_meter
//
// Measures a slow square wave (typically a programmable divider output that
// toggles every N+1 fast-clock cycles). It reports the period, the high time
// and the recovered divider setting N, all counted in clk cycles. It also
// flags loss of signal (sticky timeout) and a stable lock (two identical
// measurements in a row).
//
// Ports
//   clk        in   fast reference clock, all logic on its rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   measurement enable; low forces IDLE
//   sig_in     in   divided clock under test, may be asynchronous to clk
//   period     out  CW  cycles between the last two rising edges
//   high_time  out  CW  cycles from a rising edge to the following falling edge
//   n_est      out  CW  high_time-1 (recovered divider N), never underflows
//   valid      out  1   one-cycle strobe on each new measurement
//   stable     out  1   last two measurements identical
//   timeout    out  1   sticky; no rising edge within TIMEOUT_CYCLES
//   dbg_state  out  2   current FSM state (0 IDLE, 1 ARMED, 2 MEASURE)
//
// Handshake: valid is a pure strobe with no ready. period/high_time/n_est/
// stable are already updated in the cycle valid is high and hold until the
// next strobe, a timeout or reset.

module derived_clock_meter #(
    parameter int unsigned     CW             = 32,
    parameter int unsigned     SYNC_STAGES    = 2,
    parameter longint unsigned TIMEOUT_CYCLES = 64'h0000_0000_FFFF_FFFF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          sig_in,
    output logic [CW-1:0] period,
    output logic [CW-1:0] high_time,
    output logic [CW-1:0] n_est,
    output logic          valid,
    output logic          stable,
    output logic          timeout,
    output logic [1:0]    dbg_state
);

    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_SAT     = '1;
    localparam logic [CW-1:0] ONE         = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_MEASURE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sig_d;
    logic                   w_sig_s;
    logic                   w_rise;
    logic                   w_fall;
    logic [CW-1:0]          r_cnt;
    logic                   w_cnt_hit;
    logic [CW-1:0]          r_hi_lat;
    logic                   r_hi_seen;
    logic                   w_take_meas;
    logic                   w_timeout_hit;
    logic [CW-1:0]          r_period;
    logic [CW-1:0]          r_high_time;
    logic [CW-1:0]          r_n_est;
    logic                   r_valid;
    logic                   r_stable;
    logic                   r_timeout;

    // ------------------------------------------------------------------
    // Input conditioning: synchroniser chain, then one delay stage for
    // edge detection.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_sig_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_sig_d <= w_sig_s;
        end
    end

    assign w_sig_s   = r_sync[SYNC_STAGES-1];
    assign w_rise    = w_sig_s & ~r_sig_d;
    assign w_fall    = ~w_sig_s & r_sig_d;
    assign w_cnt_hit = (r_cnt == TIMEOUT_CNT);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state and event decode. en=0 overrides everything; a rise
    // overrides a timeout that lands in the same cycle.
    always_comb begin
        w_state_next  = r_state;
        w_take_meas   = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_next = S_ARMED;
            end
            S_ARMED: begin
                if (w_rise) begin
                    w_state_next = S_MEASURE;
                end else if (w_cnt_hit) begin
                    w_timeout_hit = 1'b1;
                end
            end
            S_MEASURE: begin
                if (w_rise) begin
                    w_take_meas = 1'b1;
                end else if (w_cnt_hit) begin
                    w_timeout_hit = 1'b1;
                    w_state_next  = S_ARMED;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (!en) begin
            w_state_next  = S_IDLE;
            w_take_meas   = 1'b0;
            w_timeout_hit = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter. Holds 1 in the cycle after a rise, so at the next
    // rise it equals the period; at a fall it equals the high time.
    // A timeout restarts it at 1 so a lost signal re-times out periodically.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!en || r_state == S_IDLE) begin
            r_cnt <= '0;
        end else if (w_rise || w_timeout_hit) begin
            r_cnt <= ONE;
        end else if (r_cnt != CNT_SAT) begin
            r_cnt <= r_cnt + ONE;
        end
    end

    // Fall latch: captures the high time of the current period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi_lat  <= '0;
            r_hi_seen <= 1'b0;
        end else if (w_fall) begin
            r_hi_lat  <= r_cnt;
            r_hi_seen <= 1'b1;
        end else if (w_rise) begin
            r_hi_seen <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Measurement outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period    <= '0;
            r_high_time <= '0;
            r_n_est     <= '0;
            r_valid     <= 1'b0;
            r_stable    <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_valid <= w_take_meas;
            if (w_take_meas) begin
                r_period    <= r_cnt;
                r_high_time <= r_hi_seen ? r_hi_lat : '0;
                r_n_est     <= (r_hi_seen && r_hi_lat != '0) ? (r_hi_lat - ONE) : '0;
                r_timeout   <= 1'b0;
                // Compared against the previous (still registered) outputs.
                r_stable    <= (r_cnt == r_period) && (r_hi_lat == r_high_time);
            end else if (w_timeout_hit) begin
                r_timeout <= 1'b1;
                // Losing the signal mid-measurement invalidates the old result;
                // a timeout while merely armed leaves it untouched.
                if (r_state == S_MEASURE) begin
                    r_period    <= '0;
                    r_high_time <= '0;
                    r_n_est     <= '0;
                    r_stable    <= 1'b0;
                end
            end
        end
    end

    assign period    = r_period;
    assign high_time = r_high_time;
    assign n_est     = r_n_est;
    assign valid     = r_valid;
    assign stable    = r_stable;
    assign timeout   = r_timeout;
    assign dbg_state = r_state;

endmodule
